// File: rtl/q_pkg.sv
// rtl/q_pkg.sv - shared constants and types for the Q-flop pipeline stage core
// Contents: default N / RESOLVE_CYCLES / META_EXTRA, resolve counter width,
//           Q-clock state type.
package q_pkg;

    localparam int N_DEF              = 5;
    localparam int RESOLVE_CYCLES_DEF = 2;
    localparam int META_EXTRA_DEF     = 3;

    // Width of each delay term (RESOLVE_CYCLES and META_EXTRA are both 0..15).
    localparam int CNT_W = 4;

    typedef enum logic {
        LCLK_LOW  = 1'b0,
        LCLK_HIGH = 1'b1
    } lclk_state_t;

endpackage

// File: rtl/q_flop_cell.sv
// rtl/q_flop_cell.sv - single Q-flop: capture, resolve countdown, ack and q
// Ports:
//   clk, rst      system clock, synchronous active-low reset
//   capture       one-cycle pulse on the local clock rising edge
//   lclk          local Q-clock level (ack is withdrawn while it is low)
//   start         forces q to 0 on any edge
//   d, meta       data bit and metastability injection, sampled at capture
//   q, ack        resolved output and resolution acknowledge
import q_pkg::*;

module q_flop_cell #(
    parameter int RESOLVE_CYCLES = RESOLVE_CYCLES_DEF,
    parameter int META_EXTRA     = META_EXTRA_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic capture,
    input  logic lclk,
    input  logic start,
    input  logic d,
    input  logic meta,
    output logic q,
    output logic ack
);

    // The loaded delay is the sum of two CNT_W-bit terms, so one extra bit.
    localparam int CW = CNT_W + 1;

    logic [CW-1:0] cnt;
    logic          stored;
    logic          resolve;

    // Resolution happens on the edge where the countdown reaches zero.
    assign resolve = !capture && (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= '0;
            stored <= 1'b0;
            ack    <= 1'b0;
            q      <= 1'b0;
        end else begin
            if (capture) begin
                stored <= d;
                cnt    <= CW'(RESOLVE_CYCLES) + (meta ? CW'(META_EXTRA) : CW'(0));
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end

            // A rise can only come from the countdown, which runs while lclk
            // is high, so rise and fall never compete on the same edge.
            if (resolve) begin
                ack <= 1'b1;
            end else if (ack && !lclk) begin
                ack <= 1'b0;
            end

            if (start) begin
                q <= 1'b0;
            end else if (resolve) begin
                q <= stored;
            end
        end
    end

endmodule

// File: rtl/q_flop_unit.sv
// rtl/q_flop_unit.sv - N Q-flops with local Q-clock generator and C-element join
// Ports:
//   clk, rst   system clock, synchronous active-low reset
//   start      synchronous flop clear (q forced to 0 while high)
//   d, meta    per-flop data and metastability injection
//   q, ack     per-flop resolved outputs and acknowledges
//   cel_ack    C-element rendezvous of all ack bits
//   lclk       local Q-clock
import q_pkg::*;

module q_flop_unit #(
    parameter int N              = N_DEF,
    parameter int RESOLVE_CYCLES = RESOLVE_CYCLES_DEF,
    parameter int META_EXTRA     = META_EXTRA_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] d,
    input  logic [N-1:0] meta,
    output logic [N-1:0] q,
    output logic [N-1:0] ack,
    output logic         cel_ack,
    output logic         lclk
);

    lclk_state_t state;
    logic        lclk_d;
    logic        capture;

    assign capture = lclk && !lclk_d;

    // Q-clock: each phase lasts until the C-element has caught up with it,
    // so the period stretches with the slowest flop's resolution.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= LCLK_LOW;
            lclk    <= 1'b0;
            lclk_d  <= 1'b0;
            cel_ack <= 1'b0;
        end else begin
            lclk_d <= lclk;

            // C-element: mixed acks hold the previous value.
            if (&ack) begin
                cel_ack <= 1'b1;
            end else if (~|ack) begin
                cel_ack <= 1'b0;
            end

            case (state)
                LCLK_LOW: begin
                    if (!cel_ack) begin
                        state <= LCLK_HIGH;
                        lclk  <= 1'b1;
                    end
                end
                LCLK_HIGH: begin
                    if (cel_ack) begin
                        state <= LCLK_LOW;
                        lclk  <= 1'b0;
                    end
                end
                default: begin
                    state <= LCLK_LOW;
                    lclk  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_cell
        q_flop_cell #(
            .RESOLVE_CYCLES (RESOLVE_CYCLES),
            .META_EXTRA     (META_EXTRA)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .capture (capture),
            .lclk    (lclk),
            .start   (start),
            .d       (d[i]),
            .meta    (meta[i]),
            .q       (q[i]),
            .ack     (ack[i])
        );
    end

endmodule

// File: tb/tb_q_flop_unit.sv
// tb/tb_q_flop_unit.sv - randomized scoreboard bench for q_flop_unit
module tb_q_flop_unit;

    localparam int N = 5;
    localparam int R = 2;
    localparam int M = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] d = '0;
    logic [N-1:0] meta = '0;
    logic [N-1:0] q;
    logic [N-1:0] ack;
    logic         cel_ack;
    logic         lclk;

    always #5 clk = ~clk;

    q_flop_unit #(
        .N              (N),
        .RESOLVE_CYCLES (R),
        .META_EXTRA     (M)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .d       (d),
        .meta    (meta),
        .q       (q),
        .ack     (ack),
        .cel_ack (cel_ack),
        .lclk    (lclk)
    );

    typedef struct packed {
        logic         lclk;
        logic         cel;
        logic [N-1:0] ack;
        logic [N-1:0] q;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference timeline: edge numbers of one local period, derived from the
    // capture edge and the slowest flop's resolution edge.
    int           e = 0;
    bit           pending = 1'b1;
    bit           have_cap = 1'b0;
    int           ps = 0;
    int           tmax = 0;
    int           t[N];
    logic [N-1:0] capd = '0;
    logic [N-1:0] qm = '0;

    function automatic void model_edge(input logic r, input logic s,
                                       input logic [N-1:0] dv, input logic [N-1:0] mv);
        exp_t x;
        x = '0;
        if (!r) begin
            pending  = 1'b1;
            have_cap = 1'b0;
            qm       = '0;
        end else begin
            if (pending) begin
                ps = e; pending = 1'b0; have_cap = 1'b0;
            end else if (have_cap && e == tmax + 5) begin
                ps = e; have_cap = 1'b0;
            end
            if (e == ps + 1) begin
                capd = dv;
                tmax = 0;
                for (int i = 0; i < N; i++) begin
                    t[i] = e + R + (mv[i] ? M : 0);
                    if (t[i] > tmax) tmax = t[i];
                end
                have_cap = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (s) qm[i] = 1'b0;
                else if (have_cap && e == t[i]) qm[i] = capd[i];
            end
            x.lclk = !have_cap || (e < tmax + 2);
            x.cel  = have_cap && (e >= tmax + 1) && (e < tmax + 4);
            for (int i = 0; i < N; i++)
                x.ack[i] = have_cap && (e >= t[i]) && (e < tmax + 3);
            x.q = qm;
        end
        sb.push_back(x);
        e++;
    endfunction

    task automatic step(input logic r, input logic s,
                        input logic [N-1:0] dv, input logic [N-1:0] mv);
        rst = r; start = s; d = dv; meta = mv;
        @(posedge clk);
        model_edge(r, s, dv, mv);
        #1;
    endtask

    function automatic void check(input string name, input int cyc,
                                  input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%b required=%b", name, cyc, act, req);
        end
    endfunction

    exp_t mon_x;
    int   mon_edge = 0;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_x = sb.pop_front();
            check("lclk",    mon_edge, N'(lclk),    N'(mon_x.lclk));
            check("cel_ack", mon_edge, N'(cel_ack), N'(mon_x.cel));
            check("ack",     mon_edge, ack,         mon_x.ack);
            check("q",       mon_edge, q,           mon_x.q);
            mon_edge++;
        end
    end

    function automatic logic [N-1:0] rnd_meta();
        return ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
    endfunction

    initial begin
        #1;
        // Reset held with data present.
        repeat (3) step(1'b0, 1'b0, 5'b10101, '0);
        // Nominal periods, constant data.
        repeat (16) step(1'b1, 1'b0, 5'b10110, '0);
        // Data toggling every cycle.
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b0, (i % 2 == 1) ? 5'b01011 : 5'b10100, '0);
        // One slow flop.
        repeat (22) step(1'b1, 1'b0, N'($urandom), 5'b00100);
        // All ones, then a single-cycle start pulse once q is populated.
        repeat (9) step(1'b1, 1'b0, 5'b11111, '0);
        step(1'b1, 1'b1, 5'b11111, '0);
        repeat (8) step(1'b1, 1'b0, 5'b11111, '0);
        // start held across a whole period.
        repeat (10) step(1'b1, 1'b1, 5'b11111, '0);
        // Random traffic.
        repeat (400) step(1'b1, ($urandom_range(0, 5) == 0), N'($urandom), rnd_meta());
        // Reset on the edge where cel_ack rises.
        for (int i = 0; i < 40; i++) begin
            if (have_cap && e == tmax + 1) break;
            step(1'b1, 1'b0, N'($urandom), '0);
        end
        step(1'b0, 1'b0, 5'b11111, '0);
        repeat (24) step(1'b1, 1'b0, 5'b10110, '0);
        repeat (150) step(1'b1, ($urandom_range(0, 7) == 0), N'($urandom), rnd_meta());

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
